// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared definitions for the bit-serial magnitude comparator.
//               FSM state encodings, result encodings ({aeb,agb,alb}) and
//               the bit-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN,
        ST_DONE = c_ST_DONE
    } state_t;

    // Result vectors ordered {aeb, agb, alb}
    localparam logic [2:0] c_RES_EQ = 3'b100;
    localparam logic [2:0] c_RES_GT = 3'b010;
    localparam logic [2:0] c_RES_LT = 3'b001;

    // Bit-index width; a 1-bit operand still needs a 1-bit index register
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_bit_cell.sv
`default_nettype none
// ============================================================================
// Module      : cmp_bit_cell
// Description : Combinational 1-bit magnitude compare cell.
// Ports       : a, b   - operand bits
//               eq     - a == b
//               gt     - a > b  (a=1, b=0)
//               lt     - a < b  (a=0, b=1)
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_bit_cell (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);

    assign eq = ~(a ^ b);
    assign gt = a & ~b;
    assign lt = ~a & b;

endmodule
`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_ctrl
// Description : Bit-serial unsigned magnitude comparator. Operands are taken
//               over a valid/ready handshake, scanned MSB->LSB one bit per
//               clock through cmp_bit_cell, and the {aeb,agb,alb} result is
//               offered over a valid/ready handshake.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - operand handshake (a, b)
//               a, b                - WIDTH-bit unsigned operands
//               out_valid/out_ready - result handshake
//               aeb, agb, alb       - result flags (qualify with out_valid)
//               busy                - high while RUN or DONE
// Parameters  : WIDTH      - operand width (>=1)
//               EARLY_EXIT - 1: stop at the first differing bit
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aeb,
    output logic             agb,
    output logic             alb,
    output logic             busy
);

    localparam int               c_IDX_W   = idx_width(WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_decided;
    logic [1:0]           r_first;      // {gt,lt} of the first differing bit
    logic [2:0]           r_res;        // {aeb,agb,alb}

    logic [WIDTH-1:0]     w_a_sh;
    logic [WIDTH-1:0]     w_b_sh;
    logic                 w_eq;
    logic                 w_gt;
    logic                 w_lt;
    logic                 w_latch;
    logic [2:0]           w_res_nxt;

    // Shift instead of a variable part-select so WIDTH=1 needs no special case
    assign w_a_sh = r_a >> r_idx;
    assign w_b_sh = r_b >> r_idx;

    cmp_bit_cell u_cell (
        .a  (w_a_sh[0]),
        .b  (w_b_sh[0]),
        .eq (w_eq),
        .gt (w_gt),
        .lt (w_lt)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and result selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_res_nxt   = r_res;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (EARLY_EXIT && !w_eq) begin
                    w_latch     = 1'b1;
                    w_res_nxt   = {1'b0, w_gt, w_lt};
                    w_state_nxt = ST_DONE;
                end else if (r_idx == '0) begin
                    w_latch     = 1'b1;
                    // The first differing bit wins; a difference on the LSB
                    // itself has not reached the sticky flag yet.
                    if (r_decided) begin
                        w_res_nxt = {1'b0, r_first};
                    end else if (!w_eq) begin
                        w_res_nxt = {1'b0, w_gt, w_lt};
                    end else begin
                        w_res_nxt = c_RES_EQ;
                    end
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, index, decided-flag and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_first   <= 2'b00;
            r_res     <= 3'b000;
        end else begin
            if (w_latch) begin
                r_res <= w_res_nxt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_idx     <= c_IDX_MAX;
                        r_decided <= 1'b0;
                        r_first   <= 2'b00;
                    end
                end
                ST_RUN: begin
                    if (!w_eq && !r_decided) begin
                        r_decided <= 1'b1;
                        r_first   <= {w_gt, w_lt};
                    end
                    // Exit happens at idx==0, so the index never wraps
                    if (!w_latch) begin
                        r_idx <= r_idx - c_IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready         = (r_state == ST_IDLE);
    assign out_valid        = (r_state == ST_DONE);
    assign busy             = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign {aeb, agb, alb}  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_cmp_ctrl
// Description : Self-checking bench for serial_cmp_ctrl. Three instances:
//               sel 0 = WIDTH 8 early exit, sel 1 = WIDTH 8 full scan,
//               sel 2 = WIDTH 1. Latency counts clock edges from the accept
//               edge (inclusive) to the edge after which out_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cmp_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_ready;
    logic [2:0] iv;
    logic [2:0] ov;
    logic [2:0] irdy;
    logic [2:0] bsy;
    logic [2:0] res0;
    logic [2:0] res1;
    logic [2:0] res2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] res;
        int         lat;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
        .aeb(res0[2]), .agb(res0[1]), .alb(res0[0]), .busy(bsy[0])
    );

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready),
        .aeb(res1[2]), .agb(res1[1]), .alb(res1[0]), .busy(bsy[1])
    );

    serial_cmp_ctrl #(.WIDTH(1), .EARLY_EXIT(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a[0:0]), .b(b[0:0]), .out_valid(ov[2]), .out_ready(out_ready),
        .aeb(res2[2]), .agb(res2[1]), .alb(res2[0]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] res_of(input int sel);
        case (sel)
            0:       return res0;
            1:       return res1;
            default: return res2;
        endcase
    endfunction

    function automatic logic [2:0] model_res(input int sel, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] m;
        m = (sel == 2) ? 8'h01 : 8'hFF;
        x = x & m;
        y = y & m;
        if (x == y) return 3'b100;
        if (x > y)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_lat(input int sel, input logic [7:0] x, input logic [7:0] y);
        int w;
        w = (sel == 2) ? 1 : 8;
        if (sel == 1) return w + 1;
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return w - i + 1;
        end
        return w + 1;
    endfunction

    // Wait (bounded) for out_valid on instance sel, then score the result
    task automatic wait_and_score(input int sel, input int lat_start);
        int   lat;
        exp_t e;
        lat = lat_start;
        while (!ov[sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_timeout", {31'd0, ov[sel]}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("result", {29'd0, res_of(sel)}, {29'd0, e.res});
            chk("latency", lat, e.lat);
        end
    endtask

    task automatic run_txn(input int sel, input logic [7:0] ta, input logic [7:0] tb2,
                           input logic [2:0] eres, input int elat);
        exp_t e;
        chk("idle_in_ready", {31'd0, irdy[sel]}, 32'd1);
        e.res = eres;
        e.lat = elat;
        sb_q.push_back(e);
        a = ta;
        b = tb2;
        iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        wait_and_score(sel, 1);
        // out_ready was already high, so the handshake completes on this edge
        @(posedge clk); #1;
        chk("release", {30'd0, ov[sel], irdy[sel]}, 32'd1);
    endtask

    vec_t tbl[18];

    initial begin
        exp_t e;
        bit   stale;
        rst = 1'b1;
        iv = 3'b000;
        a = 8'h00;
        b = 8'h00;
        out_ready = 1'b0;

        tbl[0]  = '{0, 8'h5A, 8'h5A, 3'b100, 9};
        tbl[1]  = '{0, 8'h80, 8'h7F, 3'b010, 2};
        tbl[2]  = '{0, 8'h03, 8'h04, 3'b001, 7};
        tbl[3]  = '{1, 8'h80, 8'h7F, 3'b010, 9};
        tbl[4]  = '{1, 8'h00, 8'h00, 3'b100, 9};
        tbl[5]  = '{1, 8'h01, 8'h00, 3'b010, 9};
        tbl[6]  = '{0, 8'hFF, 8'hFE, 3'b010, 9};
        tbl[7]  = '{0, 8'h00, 8'hFF, 3'b001, 2};
        tbl[8]  = '{2, 8'h01, 8'h00, 3'b010, 2};
        tbl[9]  = '{2, 8'h00, 8'h00, 3'b100, 2};
        tbl[10] = '{2, 8'h00, 8'h01, 3'b001, 2};
        tbl[11] = '{1, 8'h7F, 8'h80, 3'b001, 9};
        for (int i = 12; i < 18; i++) begin
            tbl[i].sel = int'($urandom_range(0, 2));
            tbl[i].a   = 8'($urandom);
            tbl[i].b   = (i % 2 == 0) ? (tbl[i].a ^ 8'($urandom_range(0, 7))) : 8'($urandom);
            tbl[i].res = model_res(tbl[i].sel, tbl[i].a, tbl[i].b);
            tbl[i].lat = model_lat(tbl[i].sel, tbl[i].a, tbl[i].b);
        end

        // Reset state while rst is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {29'd0, ov}, 32'd0);
        chk("rst_busy", {29'd0, bsy}, 32'd0);
        chk("rst_results", {23'd0, res0, res1, res2}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {29'd0, irdy}, 32'd7);

        // out_ready high ahead of out_valid for all table vectors
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            run_txn(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);
        end

        // Result backpressure with a second pair waiting
        out_ready = 1'b0;
        e.res = 3'b001; e.lat = 4;
        sb_q.push_back(e);
        a = 8'h10; b = 8'h20; iv[0] = 1'b1;
        @(posedge clk); #1;
        a = 8'h22; b = 8'h21;
        wait_and_score(0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, ov[0]}, 32'd1);
            chk("bp_result_stable", {29'd0, res0}, 32'd1);
            chk("bp_in_ready", {31'd0, irdy[0]}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", {30'd0, ov[0], irdy[0]}, 32'd1);
        e.res = 3'b010; e.lat = 8;
        sb_q.push_back(e);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("bp_second_accept", {30'd0, bsy[0], irdy[0]}, 32'd2);
        wait_and_score(0, 1);
        @(posedge clk); #1;
        chk("bp_release", {30'd0, ov[0], irdy[0]}, 32'd1);

        // Reset in the 3rd RUN cycle of a full-scan compare
        a = 8'hFF; b = 8'h00; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, ov[1]}, 32'd0);
        chk("mid_rst_results", {29'd0, res1}, 32'd0);
        chk("mid_rst_busy_ready", {30'd0, bsy[1], irdy[1]}, 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov[1] || bsy[1]) stale = 1'b1;
        end
        chk("mid_rst_no_stale", {31'd0, stale}, 32'd0);
        run_txn(1, 8'h42, 8'h42, 3'b100, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
